wave_seq_ctrl: RTL and testbench

Sequencing controller for the 8-bit waveform generator path. It owns the up/down sample counter and a programmable tick prescaler. It accepts waveform configurations through a valid/ready handshake and runs a burst of N periods, or runs continuously. Configuration changes made while running are shadowed and take effect only at a period boundary, so the output never glitches.

---
 rtl/wave_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_wave_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq_ctrl.sv
// ---------------------------------------------------------------------------
// wave_seq_ctrl
//
// Sequencing controller for the 8-bit waveform generator path. It owns the
// up/down sample counter and a programmable tick prescaler. Configurations
// arrive over a valid/ready handshake into a single shadow register. The
// controller then runs a burst of N periods, or runs continuously when the
// period count is zero. A configuration accepted while running is held in
// the shadow and only takes effect at a period boundary, so the sample
// stream never glitches mid-period.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   cfg_valid_i    configuration offer
//   cfg_ready_o    shadow register is free
//   cfg_mode_i     0 triangle, 1 sawtooth, 2 square, 3 treated as triangle
//   cfg_min_i      lower bound of the sample
//   cfg_max_i      upper bound of the sample
//   cfg_step_i     increment per tick (0 is treated as 1)
//   cfg_div_i      one tick every cfg_div_i+1 clocks
//   cfg_cycles_i   periods per burst, 0 = continuous
//   cfg_err_o      1-cycle pulse: accepted config discarded (min > max)
//   start_i        begin a burst (honoured in IDLE only)
//   stop_i         abort a running burst
//   wave_o         sample output
//   wave_valid_o   1-cycle pulse on the cycle wave_o holds a new sample
//   period_done_o  1-cycle pulse at each period boundary
//   busy_o         high while running
//   done_o         1-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module wave_seq_ctrl #(
    parameter int DW    = 8,
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [1:0]       cfg_mode_i,
    input  logic [DW-1:0]    cfg_min_i,
    input  logic [DW-1:0]    cfg_max_i,
    input  logic [DW-1:0]    cfg_step_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [CNT_W-1:0] cfg_cycles_i,
    output logic             cfg_err_o,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [DW-1:0]    wave_o,
    output logic             wave_valid_o,
    output logic             period_done_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mode is stored already normalised (3 folded onto triangle) and step is
    // stored with 0 folded onto 1, so the datapath never sees those cases.
    typedef struct packed {
        logic [1:0]       mode;
        logic [DW-1:0]    lo;
        logic [DW-1:0]    hi;
        logic [DW-1:0]    step;
        logic [DIV_W-1:0] div;
        logic [CNT_W-1:0] cycles;
    } cfg_t;

    state_t           state_q, state_d;
    cfg_t             act_q, act_d;
    cfg_t             shd_q, shd_d;
    logic             pending_q, pending_d;
    logic [DW-1:0]    seq_q, seq_d;
    logic             dirDown_q, dirDown_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [CNT_W-1:0] perCnt_q, perCnt_d;
    logic [DW-1:0]    wave_q, wave_d;
    logic             waveValid_q, waveValid_d;
    logic             periodDone_q, periodDone_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfgErr_q, cfgErr_d;
    logic             cfgReady_q, cfgReady_d;

    logic [DW:0]      sumUp;
    logic [DW:0]      diffDn;
    logic [DW-1:0]    upVal;
    logic [DW-1:0]    downVal;
    logic [DW-1:0]    tickSeq;
    logic             tickDir;
    logic             tickBoundary;

    // Clamped step arithmetic. Sums are one bit wider than the sample so a
    // carry or borrow is visible and the result saturates at the bound
    // instead of wrapping.
    always_comb begin
        sumUp   = {1'b0, seq_q} + {1'b0, act_q.step};
        diffDn  = {1'b0, seq_q} - {1'b0, act_q.step};
        upVal   = (sumUp > {1'b0, act_q.hi}) ? act_q.hi : sumUp[DW-1:0];
        downVal = (diffDn[DW] || (diffDn[DW-1:0] < act_q.lo)) ? act_q.lo
                                                                : diffDn[DW-1:0];
    end

    // What one prescaler tick does to the internal sample and direction.
    // Square shares the triangle walk; only the output mapping differs.
    // A degenerate range makes every tick a boundary, otherwise the
    // triangle walk would only see a boundary every second tick.
    always_comb begin
        tickSeq      = seq_q;
        tickDir      = dirDown_q;
        tickBoundary = 1'b0;
        if (act_q.lo == act_q.hi) begin
            tickSeq      = act_q.lo;
            tickDir      = 1'b0;
            tickBoundary = 1'b1;
        end else if (act_q.mode == 2'd1) begin
            tickDir = 1'b0;
            if (seq_q == act_q.hi) begin
                tickSeq      = act_q.lo;
                tickBoundary = 1'b1;
            end else begin
                tickSeq = upVal;
            end
        end else if (!dirDown_q) begin
            if (seq_q == act_q.hi) begin
                tickDir = 1'b1;
                tickSeq = downVal;
            end else begin
                tickSeq = upVal;
            end
        end else begin
            if (seq_q == act_q.lo) begin
                tickDir      = 1'b0;
                tickSeq      = upVal;
                tickBoundary = 1'b1;
            end else begin
                tickSeq = downVal;
            end
        end
    end

    // Next-state logic for the sequencer, the handshake and all outputs.
    // The handshake only looks at the registered ready, so a shadow that is
    // being applied this cycle can never be overwritten in the same cycle.
    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        shd_d        = shd_q;
        pending_d    = pending_q;
        seq_d        = seq_q;
        dirDown_d    = dirDown_q;
        divCnt_d     = divCnt_q;
        perCnt_d     = perCnt_q;
        wave_d       = wave_q;
        waveValid_d  = 1'b0;
        periodDone_d = 1'b0;
        cfgErr_d     = 1'b0;

        if (cfg_valid_i && cfgReady_q) begin
            if (cfg_min_i > cfg_max_i) begin
                cfgErr_d = 1'b1;
            end else begin
                shd_d.mode   = (cfg_mode_i == 2'd3) ? 2'd0 : cfg_mode_i;
                shd_d.lo     = cfg_min_i;
                shd_d.hi     = cfg_max_i;
                shd_d.step   = (cfg_step_i == '0) ? DW'(1) : cfg_step_i;
                shd_d.div    = cfg_div_i;
                shd_d.cycles = cfg_cycles_i;
                pending_d    = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    act_d     = shd_q;
                    pending_d = 1'b0;
                end
                if (start_i) begin
                    state_d   = RUN;
                    seq_d     = act_d.lo;
                    dirDown_d = 1'b0;
                    divCnt_d  = '0;
                    perCnt_d  = '0;
                    wave_d    = act_d.lo;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d   = IDLE;
                    seq_d     = act_q.lo;
                    dirDown_d = 1'b0;
                    divCnt_d  = '0;
                    wave_d    = act_q.lo;
                end else if (divCnt_q == act_q.div) begin
                    divCnt_d    = '0;
                    waveValid_d = 1'b1;
                    seq_d       = tickSeq;
                    dirDown_d   = tickDir;
                    if (tickBoundary) begin
                        periodDone_d = 1'b1;
                        // A pending shadow restarts the burst under the new
                        // configuration, so it takes priority over completion.
                        if (pending_q) begin
                            act_d     = shd_q;
                            pending_d = 1'b0;
                            seq_d     = shd_q.lo;
                            dirDown_d = 1'b0;
                            perCnt_d  = '0;
                        end else begin
                            perCnt_d = perCnt_q + CNT_W'(1);
                            if ((act_q.cycles != '0) && (perCnt_d == act_q.cycles)) begin
                                state_d = DONE;
                            end
                        end
                    end
                    wave_d = (act_d.mode == 2'd2) ? (dirDown_d ? act_d.hi : act_d.lo)
                                                  : seq_d;
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            DONE: begin
                if (pending_q) begin
                    act_d     = shd_q;
                    pending_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == RUN);
        done_d     = (state_d == DONE);
        cfgReady_d = !pending_d;
    end

    // State and output registers. Reset restores the default configuration
    // and drops any shadowed configuration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            act_q.mode    <= 2'd0;
            act_q.lo      <= '0;
            act_q.hi      <= '1;
            act_q.step    <= DW'(1);
            act_q.div     <= '0;
            act_q.cycles  <= '0;
            shd_q         <= '0;
            pending_q     <= 1'b0;
            seq_q         <= '0;
            dirDown_q     <= 1'b0;
            divCnt_q      <= '0;
            perCnt_q      <= '0;
            wave_q        <= '0;
            waveValid_q   <= 1'b0;
            periodDone_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfgErr_q      <= 1'b0;
            cfgReady_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            shd_q         <= shd_d;
            pending_q     <= pending_d;
            seq_q         <= seq_d;
            dirDown_q     <= dirDown_d;
            divCnt_q      <= divCnt_d;
            perCnt_q      <= perCnt_d;
            wave_q        <= wave_d;
            waveValid_q   <= waveValid_d;
            periodDone_q  <= periodDone_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfgErr_q      <= cfgErr_d;
            cfgReady_q    <= cfgReady_d;
        end
    end

    assign cfg_ready_o   = cfgReady_q;
    assign cfg_err_o     = cfgErr_q;
    assign wave_o        = wave_q;
    assign wave_valid_o  = waveValid_q;
    assign period_done_o = periodDone_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_seq_ctrl
//
// Self-checking bench for wave_seq_ctrl. A reference model predicts every
// output cycle by cycle. The waveform itself is modelled as a precomputed
// list of the samples in one period that is walked tick by tick, with the
// boundary marked in the list. Directed scenarios come first, then a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_wave_seq_ctrl;

    localparam int DW    = 8;
    localparam int DIV_W = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [DW-1:0]    cfg_min;
    logic [DW-1:0]    cfg_max;
    logic [DW-1:0]    cfg_step;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_cycles;
    logic             cfg_err;
    logic             start;
    logic             stop;
    logic [DW-1:0]    wave;
    logic             wave_valid;
    logic             period_done;
    logic             busy;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int  mState;
    int  aMode, aLo, aHi, aStep, aDiv, aCyc;
    int  sMode, sLo, sHi, sStep, sDiv, sCyc;
    bit  mPending;
    int  lstVal[$];
    int  lstSq[$];
    bit  lstBnd[$];
    int  idx;
    bit  skipBnd;
    int  divCnt, perCnt;
    int  eWave;
    bit  eValid, ePd, eDone, eBusy, eErr, eReady;

    wave_seq_ctrl #(.DW(DW), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_mode_i    (cfg_mode),
        .cfg_min_i     (cfg_min),
        .cfg_max_i     (cfg_max),
        .cfg_step_i    (cfg_step),
        .cfg_div_i     (cfg_div),
        .cfg_cycles_i  (cfg_cycles),
        .cfg_err_o     (cfg_err),
        .start_i       (start),
        .stop_i        (stop),
        .wave_o        (wave),
        .wave_valid_o  (wave_valid),
        .period_done_o (period_done),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("wave",        32'(wave),        32'(eWave));
        checkOne("wave_valid",  32'(wave_valid),  32'(eValid));
        checkOne("period_done", 32'(period_done), 32'(ePd));
        checkOne("done",        32'(done),        32'(eDone));
        checkOne("busy",        32'(busy),        32'(eBusy));
        checkOne("cfg_err",     32'(cfg_err),     32'(eErr));
        checkOne("cfg_ready",   32'(cfg_ready),   32'(eReady));
    endtask

    // One period of samples as the ticks emit them, starting from the tick
    // after the sample sits at min with the direction going up.
    task automatic buildList();
        int v;
        lstVal.delete();
        lstSq.delete();
        lstBnd.delete();
        if (aLo == aHi) begin
            lstVal.push_back(aLo); lstSq.push_back(aLo); lstBnd.push_back(1'b1);
        end else if (aMode == 1) begin
            v = aLo;
            do begin
                v = (v + aStep > aHi) ? aHi : v + aStep;
                lstVal.push_back(v); lstSq.push_back(v); lstBnd.push_back(1'b0);
            end while (v != aHi);
            lstVal.push_back(aLo); lstSq.push_back(aLo); lstBnd.push_back(1'b1);
        end else begin
            v = aLo;
            do begin
                v = (v + aStep > aHi) ? aHi : v + aStep;
                lstVal.push_back(v); lstSq.push_back(aLo);
                lstBnd.push_back(lstVal.size() == 1);
            end while (v != aHi);
            do begin
                v = (v - aStep < aLo) ? aLo : v - aStep;
                lstVal.push_back(v); lstSq.push_back(aHi); lstBnd.push_back(1'b0);
            end while (v != aLo);
        end
    endtask

    task automatic applyShadow();
        aMode = sMode; aLo = sLo; aHi = sHi; aStep = sStep; aDiv = sDiv; aCyc = sCyc;
    endtask

    task automatic modelReset();
        mState = 0;
        aMode = 0; aLo = 0; aHi = 255; aStep = 1; aDiv = 0; aCyc = 0;
        mPending = 1'b0;
        idx = 0; skipBnd = 1'b0; divCnt = 0; perCnt = 0;
        eWave = 0; eValid = 0; ePd = 0; eDone = 0; eBusy = 0; eErr = 0; eReady = 1;
    endtask

    // Predicts the outputs after the coming clock edge from current inputs.
    task automatic modelEdge();
        bit nP;
        bit bnd;
        int outV;
        eValid = 0; ePd = 0; eErr = 0;
        nP = mPending;
        if (cfg_valid && eReady) begin
            if (cfg_min > cfg_max) begin
                eErr = 1;
            end else begin
                sMode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
                sLo   = int'(cfg_min);
                sHi   = int'(cfg_max);
                sStep = (cfg_step == '0) ? 1 : int'(cfg_step);
                sDiv  = int'(cfg_div);
                sCyc  = int'(cfg_cycles);
                nP    = 1'b1;
            end
        end
        if (mState == 0) begin
            if (mPending) begin applyShadow(); nP = 1'b0; end
            if (start) begin
                mState = 1; buildList(); idx = 0; skipBnd = (aLo != aHi);
                divCnt = 0; perCnt = 0; eWave = aLo;
            end
        end else if (mState == 2) begin
            if (mPending) begin applyShadow(); nP = 1'b0; end
            mState = 0;
        end else begin
            if (stop) begin
                mState = 0; eWave = aLo;
            end else if (divCnt == aDiv) begin
                divCnt = 0; eValid = 1;
                bnd  = lstBnd[idx] && !(idx == 0 && skipBnd);
                outV = (aMode == 2) ? lstSq[idx] : lstVal[idx];
                if (idx == 0) skipBnd = 1'b0;
                idx = (idx + 1) % lstVal.size();
                if (bnd) begin
                    ePd = 1;
                    if (mPending) begin
                        applyShadow(); nP = 1'b0; buildList(); idx = 0;
                        skipBnd = (aLo != aHi); perCnt = 0; eWave = aLo;
                    end else begin
                        perCnt++; eWave = outV;
                        if (aCyc != 0 && perCnt == aCyc) mState = 2;
                    end
                end else begin
                    eWave = outV;
                end
            end else begin
                divCnt++;
            end
        end
        mPending = nP;
        eReady = !nP;
        eBusy  = (mState == 1);
        eDone  = (mState == 2);
    endtask

    // Drives one clock cycle of inputs and checks the outputs afterwards.
    task automatic applyStimulus(input logic r, input logic v, input logic s, input logic p);
        rst = r; cfg_valid = v; start = s; stop = p;
        if (r) modelReset(); else modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic setCfg(input int m, input int lo, input int hi, input int st,
                          input int dv, input int cy);
        cfg_mode   = 2'(m);
        cfg_min    = DW'(lo);
        cfg_max    = DW'(hi);
        cfg_step   = DW'(st);
        cfg_div    = DIV_W'(dv);
        cfg_cycles = CNT_W'(cy);
    endtask

    initial begin
        int pdCount;
        int doneCount;
        bit seen;
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        setCfg(0, 0, 255, 1, 0, 0);
        modelReset();
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOne("rst_wave", 32'(wave), 32'd0);
        checkOne("rst_ready", 32'(cfg_ready), 32'd1);

        $display("[TB] default triangle");
        applyStimulus(0, 0, 1, 0);
        for (int i = 1; i <= 512; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (i == 255) checkOne("t1_peak", 32'(wave), 32'd255);
            if (i == 510) checkOne("t1_trough", 32'(wave), 32'd0);
            if (i == 511) checkOne("t1_bnd_wave", 32'(wave), 32'd1);
            if (i == 511) checkOne("t1_bnd_pd", 32'(period_done), 32'd1);
        end
        applyStimulus(0, 0, 0, 1);

        $display("[TB] sawtooth burst");
        setCfg(1, 10, 20, 4, 2, 3);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        pdCount = 0; doneCount = 0;
        for (int i = 1; i <= 60; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (i == 3) checkOne("t2_first_tick", 32'(wave), 32'd14);
            if (i == 9) checkOne("t2_clamp", 32'(wave), 32'd20);
            if (period_done) pdCount++;
            if (done) doneCount++;
        end
        checkOne("t2_pd_count", 32'(pdCount), 32'd3);
        checkOne("t2_done_count", 32'(doneCount), 32'd1);
        checkOne("t2_busy_end", 32'(busy), 32'd0);

        $display("[TB] square then stop");
        setCfg(2, 0, 100, 50, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (i == 2) checkOne("t3_low", 32'(wave), 32'd0);
            if (i == 3) checkOne("t3_high", 32'(wave), 32'd100);
        end
        applyStimulus(0, 0, 0, 1);
        checkOne("t3_stop_wave", 32'(wave), 32'd0);
        checkOne("t3_stop_busy", 32'(busy), 32'd0);

        $display("[TB] shadowed config while running");
        setCfg(0, 0, 255, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);
        setCfg(0, 0, 16, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOne("t4_ready_low", 32'(cfg_ready), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (period_done) seen = 1'b1;
        end
        checkOne("t4_boundary_seen", 32'(seen), 32'd1);
        checkOne("t4_bnd_wave", 32'(wave), 32'd0);
        checkOne("t4_bnd_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] bad config and zero step");
        setCfg(0, 50, 40, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOne("t5_err", 32'(cfg_err), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOne("t5_err_clear", 32'(cfg_err), 32'd0);
        setCfg(0, 0, 5, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOne("t5_step0", 32'(wave), 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] reset mid-burst with pending shadow");
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        setCfg(0, 3, 9, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOne("t6_wave", 32'(wave), 32'd0);
        checkOne("t6_busy", 32'(busy), 32'd0);
        checkOne("t6_ready", 32'(cfg_ready), 32'd1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (i == 255) checkOne("t6_default_peak", 32'(wave), 32'd255);
        end
        applyStimulus(0, 0, 0, 1);

        $display("[TB] randomized phase");
        for (int i = 0; i < 3000; i++) begin
            setCfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 60)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
